bp_resolve_unit: RTL and testbench

//  Branch resolution end of the Gshare predictor interface. Fetch pushes each predicted branch
//  (PC, predicted direction, PHT index) into an in-order queue. Execute pops the oldest entry,

---
 rtl/bp_resolve_unit.sv | 115 +++++++++++
 tb/tb_bp_resolve_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_unit.sv
// Branch resolution queue between fetch and execute: trains the PHT on every
// resolved branch and raises a flush/redirect when fetch guessed wrong.
module bp_resolve_unit #(
  parameter int PC_W  = 14,
  parameter int IDX_W = 14,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [PC_W-1:0]  push_pc,
  input  logic             push_pred,
  input  logic [IDX_W-1:0] push_idx,
  output logic             push_ready,
  input  logic             res_valid,
  input  logic [PC_W-1:0]  res_pc,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_next_pc,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [AW:0]      rd_ptr, wr_ptr;
  logic [PC_W-1:0]  q_pc   [DEPTH];
  logic             q_pred [DEPTH];
  logic [IDX_W-1:0] q_idx  [DEPTH];

  logic             empty, full;
  logic             pop, pc_match, mispred;
  logic             push_ok, push_err, res_err, do_write;
  logic [PC_W-1:0]  head_pc;
  logic             head_pred;
  logic [IDX_W-1:0] head_idx;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign push_ready = !full;

  assign head_pc   = q_pc[rd_ptr[AW-1:0]];
  assign head_pred = q_pred[rd_ptr[AW-1:0]];
  assign head_idx  = q_idx[rd_ptr[AW-1:0]];

  assign pop      = res_valid && !empty;
  assign res_err  = res_valid && empty;
  assign pc_match = (res_pc == head_pc);
  assign mispred  = pop && (!pc_match || (head_pred != res_taken));

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_valid && (!full || pop);
  assign push_err = push_valid && !push_ok;
  assign do_write = push_ok && !mispred;

  always_ff @(posedge clk) begin
    if (do_write) begin
      q_pc[wr_ptr[AW-1:0]]   <= push_pc;
      q_pred[wr_ptr[AW-1:0]] <= push_pred;
      q_idx[wr_ptr[AW-1:0]]  <= push_idx;
    end
  end

  // A flush discards every younger entry and any same-cycle wrong-path push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (mispred) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_taken   <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      err         <= 1'b0;
    end else begin
      upd_valid   <= pop && pc_match;
      upd_idx     <= (pop && pc_match) ? head_idx : '0;
      upd_taken   <= pop && pc_match && res_taken;
      flush       <= mispred;
      redirect_pc <= mispred ? res_next_pc : '0;
      err         <= err || push_err || res_err || (pop && !pc_match);
    end
  end

  // Statistics saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (pop && (branch_cnt != '1))      branch_cnt  <= branch_cnt + CNT_ONE;
      if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Self-checking bench for bp_resolve_unit: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_bp_resolve_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [13:0] pc;
    logic        pred;
    logic [13:0] idx;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid, push_pred, res_valid, res_taken;
  logic [13:0] push_pc, push_idx, res_pc, res_next_pc;

  logic        push_ready, upd_valid, upd_taken, flush, err;
  logic [13:0] upd_idx, redirect_pc;
  logic [31:0] branch_cnt, mispred_cnt;

  logic        sat_push_ready, sat_upd_valid, sat_upd_taken, sat_flush, sat_err;
  logic [13:0] sat_upd_idx, sat_redirect_pc;
  logic [3:0]  sat_branch_cnt, sat_mispred_cnt;

  entry_t      model_q[$];
  int unsigned m_bcnt, m_mcnt;
  bit          m_err;
  int          test_count = 0;
  int          fail_count = 0;

  always #5 clk = ~clk;

  bp_resolve_unit dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred), .push_idx(push_idx),
    .push_ready(push_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_next_pc(res_next_pc),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .err(err),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  bp_resolve_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred), .push_idx(push_idx),
    .push_ready(sat_push_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_next_pc(res_next_pc),
    .upd_valid(sat_upd_valid), .upd_idx(sat_upd_idx), .upd_taken(sat_upd_taken),
    .flush(sat_flush), .redirect_pc(sat_redirect_pc), .err(sat_err),
    .branch_cnt(sat_branch_cnt), .mispred_cnt(sat_mispred_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, advances the model, then checks the registered results.
  task automatic applyStimulus(input logic pv, input logic [13:0] ppc, input logic ppred,
                               input logic [13:0] pidx, input logic rv, input logic [13:0] rpc,
                               input logic rtaken, input logic [13:0] rnext);
    entry_t      h, ne;
    bit          e_upd, e_flush, e_taken, pop, full, accept;
    logic [13:0] e_idx, e_redir;
    e_upd = 0; e_flush = 0; e_taken = 0; e_idx = '0; e_redir = '0;
    push_valid = pv; push_pc = ppc; push_pred = ppred; push_idx = pidx;
    res_valid = rv; res_pc = rpc; res_taken = rtaken; res_next_pc = rnext;

    checkOutput("push_ready_pre", {63'd0, push_ready}, {63'd0, model_q.size() < DEPTH});
    full = (model_q.size() == DEPTH);
    pop  = rv && (model_q.size() != 0);
    if (rv && !pop) m_err = 1;
    if (pop) begin
      h = model_q[0];
      m_bcnt++;
      if (h.pc == rpc) begin
        e_upd = 1; e_idx = h.idx; e_taken = rtaken;
        if (h.pred != rtaken) e_flush = 1;
      end else begin
        m_err = 1; e_flush = 1;
      end
    end
    if (e_flush) e_redir = rnext;
    accept = pv && (!full || pop);
    if (pv && !accept) m_err = 1;
    if (e_flush) begin
      model_q.delete();
      m_mcnt++;
    end else begin
      if (pop) model_q.delete(0);
      if (accept) begin
        ne.pc = ppc; ne.pred = ppred; ne.idx = pidx;
        model_q.push_back(ne);
      end
    end

    @(posedge clk);
    #1;
    checkOutput("upd_valid", {63'd0, upd_valid}, {63'd0, e_upd});
    if (e_upd) begin
      checkOutput("upd_idx", {50'd0, upd_idx}, {50'd0, e_idx});
      checkOutput("upd_taken", {63'd0, upd_taken}, {63'd0, e_taken});
    end
    checkOutput("flush", {63'd0, flush}, {63'd0, e_flush});
    checkOutput("redirect_pc", {50'd0, redirect_pc}, {50'd0, e_redir});
    checkOutput("err", {63'd0, err}, {63'd0, m_err});
    checkOutput("branch_cnt", {32'd0, branch_cnt}, {32'd0, m_bcnt});
    checkOutput("mispred_cnt", {32'd0, mispred_cnt}, {32'd0, m_mcnt});
    checkOutput("sat_branch_cnt", {60'd0, sat_branch_cnt}, 64'((m_bcnt > 15) ? 15 : m_bcnt));
    checkOutput("sat_mispred_cnt", {60'd0, sat_mispred_cnt}, 64'((m_mcnt > 15) ? 15 : m_mcnt));
    checkOutput("push_ready", {63'd0, push_ready}, {63'd0, model_q.size() < DEPTH});
  endtask

  task automatic idle();
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic pushOnly(input logic [13:0] pc, input logic pred, input logic [13:0] idx);
    applyStimulus(1, pc, pred, idx, 0, '0, 0, '0);
  endtask

  task automatic resolveOnly(input logic [13:0] pc, input logic taken, input logic [13:0] nxt);
    applyStimulus(0, '0, 0, '0, 1, pc, taken, nxt);
  endtask

  // Asserts reset between clock edges and expects every output to clear at once.
  task automatic doReset();
    push_valid = 0; res_valid = 0;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_upd_valid", {63'd0, upd_valid}, 64'd0);
    checkOutput("rst_flush", {63'd0, flush}, 64'd0);
    checkOutput("rst_redirect", {50'd0, redirect_pc}, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);
    checkOutput("rst_branch_cnt", {32'd0, branch_cnt}, 64'd0);
    checkOutput("rst_mispred_cnt", {32'd0, mispred_cnt}, 64'd0);
    checkOutput("rst_push_ready", {63'd0, push_ready}, 64'd1);
    model_q.delete();
    m_bcnt = 0; m_mcnt = 0; m_err = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    push_valid = 0; push_pc = '0; push_pred = 0; push_idx = '0;
    res_valid = 0; res_pc = '0; res_taken = 0; res_next_pc = '0;
    model_q.delete();
    m_bcnt = 0; m_mcnt = 0; m_err = 0;
    doReset();

    // Correct prediction trains the PHT without a flush.
    pushOnly(14'h010, 1, 14'h3A5);
    resolveOnly(14'h010, 1, 14'h014);
    idle();

    // Mispredict flushes younger entries; a resolve into the empty queue is an error.
    pushOnly(14'h020, 0, 14'h001);
    pushOnly(14'h024, 1, 14'h002);
    pushOnly(14'h028, 0, 14'h003);
    resolveOnly(14'h020, 1, 14'h200);
    idle();
    resolveOnly(14'h024, 1, 14'h100);
    idle();

    // Async reset with three entries in flight and non-zero counters.
    pushOnly(14'h030, 1, 14'h011);
    pushOnly(14'h034, 1, 14'h012);
    pushOnly(14'h038, 1, 14'h013);
    doReset();

    // Fill, push+pop while full, push while full, then drain in order.
    for (int i = 0; i < DEPTH; i++) pushOnly(14'(14'h100 + i), 1, 14'(14'h050 + i));
    applyStimulus(1, 14'h1F0, 1, 14'h0AA, 1, 14'h100, 1, 14'h000);
    pushOnly(14'h1F4, 1, 14'h0BB);
    resolveOnly(14'h101, 1, 14'h0);
    resolveOnly(14'h102, 1, 14'h0);
    resolveOnly(14'h103, 1, 14'h0);
    resolveOnly(14'h1F0, 1, 14'h0);
    idle();
    doReset();

    // Pointer wrap: back-to-back push/pop pairs.
    pushOnly(14'h200, 1, 14'h060);
    for (int i = 1; i <= 10; i++)
      applyStimulus(1, 14'(14'h200 + i), 1, 14'(14'h060 + i), 1, 14'(14'h200 + i - 1), 1, 14'h0);
    resolveOnly(14'h20A, 1, 14'h0);
    idle();
    doReset();

    // Counter saturation on the narrow instance.
    for (int i = 0; i < 20; i++) begin
      pushOnly(14'(14'h300 + i), 0, 14'(i));
      resolveOnly(14'(14'h300 + i), 1, 14'(14'h380 + i));
    end
    idle();
    doReset();

    // Random traffic: mostly matching PCs and correct predictions.
    for (int n = 0; n < 400; n++) begin
      logic        pv, rv, pred, taken;
      logic [13:0] ppc, pidx, rpc, nxt;
      pv    = ($urandom_range(0, 2) != 0);
      rv    = ($urandom_range(0, 2) != 0);
      ppc   = 14'($urandom);
      pidx  = 14'($urandom);
      pred  = 1'($urandom);
      nxt   = 14'($urandom);
      rpc   = 14'($urandom);
      taken = 1'($urandom);
      if (model_q.size() != 0) begin
        if ($urandom_range(0, 7) != 0) rpc = model_q[0].pc;
        if ($urandom_range(0, 3) != 0) taken = model_q[0].pred;
      end
      applyStimulus(pv, ppc, pred, pidx, rv, rpc, taken, nxt);
      if (n == 200) doReset();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
